// File: rtl/mem_access_pkg.sv
// Shared decode patterns, funct3 encodings and memory-stage types for the RV32I memory stage.
package mem_access_pkg;

    localparam logic [31:0] I_ALL_LOADS = 32'b???????_?????_?????_???_?????_0000011;
    localparam logic [31:0] S_ALL       = 32'b???????_?????_?????_???_?????_0100011;
    localparam logic [31:0] R_ALL       = 32'b???????_?????_?????_???_?????_0110011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [1:0]  offset;
    } mem_op_t;

    function automatic logic is_load(input logic [31:0] instr);
        logic r;
        r = 1'b0;
        casez (instr)
            I_ALL_LOADS: r = instr[14:12] inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_store(input logic [31:0] instr);
        logic r;
        r = 1'b0;
        casez (instr)
            S_ALL:   r = instr[14:12] inside {F3_B, F3_H, F3_W};
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_rtype(input logic [31:0] instr);
        logic r;
        r = 1'b0;
        casez (instr)
            R_ALL:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // funct3[1:0] encodes access size for both loads and stores.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        return (funct3[1:0] == 2'b01 && offset[0]) ||
               (funct3[1:0] == 2'b10 && offset != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_lsu_format.sv
// Load lane extract/extend and store byte-enable/lane-replication, purely combinational.
module lsu_format
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [3:0]  be,
    output logic [31:0] wdata
);
    localparam int NUM_LANES = 4;

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_BU:   load_data = {24'h0, lane_b};
            F3_HU:   load_data = {16'h0, lane_h};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << offset;
            2'b01:   be = 4'b0011 << offset;
            default: be = 4'b1111;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign wdata[8*i +: 8] = (funct3[1:0] == 2'b00) ? store_data[7:0] :
                                 (funct3[1:0] == 2'b01) ? store_data[8*(i%2) +: 8] :
                                                          store_data[8*i +: 8];
    end

endmodule

// File: rtl/mem_access.sv
// RV32I memory stage: runs the req/gnt/rvalid data port, stalls upstream, registers the writeback bundle.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] rs2_i,
    input  logic [4:0]  sel_rd_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] wb_instr_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_we_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESP_TIMEOUT - 1);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_q;
    mem_op_t          op_q;

    logic is_ld, is_st, is_mem, is_r, mis;
    logic stall, start, ld_done, st_done, abort;
    logic [2:0]  fmt_f3;
    logic [1:0]  fmt_off;
    logic [31:0] fmt_load, fmt_wdata;
    logic [3:0]  fmt_be;

    assign is_ld  = is_load(instr_i);
    assign is_st  = is_store(instr_i);
    assign is_mem = is_ld | is_st;
    assign is_r   = is_rtype(instr_i);
    assign mis    = is_mem && misaligned(instr_i[14:12], alu_result_i[1:0]);

    // Store lanes are built from the incoming op in IDLE; load formatting uses the captured op.
    assign fmt_f3  = (state_q == IDLE) ? instr_i[14:12]      : op_q.funct3;
    assign fmt_off = (state_q == IDLE) ? alu_result_i[1:0]   : op_q.offset;

    lsu_format u_fmt (
        .funct3     (fmt_f3),
        .offset     (fmt_off),
        .rdata      (dmem_rdata_i),
        .store_data (rs2_i),
        .load_data  (fmt_load),
        .be         (fmt_be),
        .wdata      (fmt_wdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        start   = 1'b0;
        ld_done = 1'b0;
        st_done = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mem && !mis) begin
                    stall   = 1'b1;
                    start   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dmem_gnt_i) begin
                    if (req_q.we) begin
                        stall   = 1'b0;
                        st_done = 1'b1;
                        state_d = IDLE;
                    end else if (dmem_rvalid_i) begin
                        stall   = 1'b0;
                        ld_done = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                stall = 1'b1;
                if (dmem_rvalid_i) begin
                    stall   = 1'b0;
                    ld_done = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    stall   = 1'b0;
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated so a held memory instruction cannot raise stall while reset is asserted.
    assign stall_o      = rst_n & stall;
    assign dmem_req_o   = (state_q == REQ);
    assign dmem_we_o    = req_q.we;
    assign dmem_addr_o  = req_q.addr;
    assign dmem_be_o    = req_q.be;
    assign dmem_wdata_o = req_q.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            op_q       <= '0;
            wb_instr_o <= '0;
            wb_data_o  <= '0;
            wb_rd_o    <= '0;
            wb_we_o    <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_we_o    <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            if (start) begin
                req_q <= '{we: is_st, addr: {alu_result_i[31:2], 2'b00}, be: fmt_be, wdata: fmt_wdata};
                op_q  <= '{instr: instr_i, rd: sel_rd_i, funct3: instr_i[14:12], offset: alu_result_i[1:0]};
            end
            if (state_q == IDLE && !start) begin
                wb_instr_o <= instr_i;
                wb_data_o  <= alu_result_i;
                wb_rd_o    <= sel_rd_i;
                wb_we_o    <= is_r && (sel_rd_i != 5'd0);
                misalign_o <= mis;
            end
            if (st_done) wb_instr_o <= op_q.instr;
            if (ld_done) begin
                wb_instr_o <= op_q.instr;
                wb_data_o  <= fmt_load;
                wb_rd_o    <= op_q.rd;
                wb_we_o    <= (op_q.rd != 5'd0);
            end
            if (abort) begin
                wb_instr_o <= op_q.instr;
                bus_err_o  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: hand-computed vector table, random ops against a transaction-level model, reset corner.
module tb_mem_access;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_i, alu_result_i, rs2_i, dmem_rdata_i;
    logic [4:0]  sel_rd_i;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic        stall_o, dmem_req_o, dmem_we_o, wb_we_o, misalign_o, bus_err_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, wb_instr_o, wb_data_o;
    logic [3:0]  dmem_be_o;
    logic [4:0]  wb_rd_o;

    always #5 clk = ~clk;

    mem_access #(.RESP_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .alu_result_i(alu_result_i),
        .rs2_i(rs2_i), .sel_rd_i(sel_rd_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .wb_instr_o(wb_instr_o), .wb_data_o(wb_data_o),
        .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    typedef struct {
        logic [31:0] instr, alu, rs2, rdata;
        logic [4:0]  rd;
        int          gnt_dly, rv_dly;
        logic [31:0] e_addr, e_wdata, e_data;
        logic [3:0]  e_be;
        logic        e_we, e_mis, e_err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
        return {17'h0, f3, rd, opc};
    endfunction

    function automatic int kind_of(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        if (ins[6:0] == 7'h03 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 2;
        if (ins[6:0] == 7'h23 && f3 <= 3'd2) return 3;
        if (ins[6:0] == 7'h33) return 1;
        return 0;
    endfunction

    function automatic int size_of(input logic [31:0] ins);
        return (ins[13:12] == 2'd0) ? 1 : (ins[13:12] == 2'd1) ? 2 : 4;
    endfunction

    function automatic vec_t tv(input logic [31:0] instr, alu, rs2, input logic [4:0] rd,
                                input int g, r, input logic [31:0] rdata, e_addr,
                                input logic [3:0] e_be, input logic [31:0] e_wdata, e_data,
                                input logic e_we, e_mis, e_err);
        vec_t v;
        v.instr = instr; v.alu = alu; v.rs2 = rs2; v.rd = rd; v.gnt_dly = g; v.rv_dly = r;
        v.rdata = rdata; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
        v.e_data = e_data; v.e_we = e_we; v.e_mis = e_mis; v.e_err = e_err;
        return v;
    endfunction

    // Expected results straight from the architectural rules: sizes, shifts, masks, timeout bound.
    function automatic vec_t model(input vec_t v);
        int k, sz, off;
        logic [31:0] sh, val;
        k   = kind_of(v.instr);
        sz  = size_of(v.instr);
        off = int'(v.alu % 4);
        v.e_mis  = (k >= 2) && ((v.alu % sz) != 0);
        v.e_err  = (k == 2) && !v.e_mis && (v.rv_dly > TO);
        v.e_addr = v.alu & ~32'd3;
        v.e_be   = 4'(((1 << sz) - 1) << off);
        v.e_wdata = (sz == 1) ? {4{v.rs2[7:0]}} : (sz == 2) ? {2{v.rs2[15:0]}} : v.rs2;
        sh = v.rdata >> (8 * off);
        if (sz == 1) begin
            val = sh & 32'hFF;
            if (v.instr[14] == 1'b0 && val[7]) val = val | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            val = sh & 32'hFFFF;
            if (v.instr[14] == 1'b0 && val[15]) val = val | 32'hFFFF_0000;
        end else val = v.rdata;
        v.e_data = (k == 2) ? val : v.alu;
        v.e_we   = (k == 1 || (k == 2 && !v.e_mis && !v.e_err)) && (v.rd != 5'd0);
        return v;
    endfunction

    task automatic run_op(input vec_t v, input string nm);
        int  k, n, gc, rc;
        logic mem, real_rv, exp_req;
        k   = kind_of(v.instr);
        mem = (k >= 2) && !v.e_mis;
        gc  = 1 + v.gnt_dly;
        rc  = (v.rv_dly > TO) ? -1 : gc + v.rv_dly;
        if (!mem) n = 0;
        else if (k == 3) n = gc;
        else n = gc + ((v.rv_dly > TO) ? TO : v.rv_dly);
        for (int c = 0; c <= n; c++) begin
            if (c > 0) chk({nm, ".bubble"}, 32'({wb_we_o, misalign_o, bus_err_o}), 32'd0);
            instr_i = v.instr; alu_result_i = v.alu; rs2_i = v.rs2; sel_rd_i = v.rd;
            dmem_gnt_i = mem && (c == gc);
            real_rv = mem && (k == 2) && (c == rc);
            dmem_rvalid_i = real_rv ? 1'b1 : (c <= v.gnt_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
            dmem_rdata_i  = real_rv ? v.rdata : $urandom;
            #1;
            chk({nm, ".stall"}, 32'(stall_o), 32'(c < n));
            exp_req = mem && c >= 1 && c <= gc;
            chk({nm, ".req"}, 32'(dmem_req_o), 32'(exp_req));
            if (exp_req) begin
                chk({nm, ".addr"}, dmem_addr_o, v.e_addr);
                chk({nm, ".we"}, 32'(dmem_we_o), 32'(k == 3));
                if (k == 3) begin
                    chk({nm, ".be"}, 32'(dmem_be_o), 32'(v.e_be));
                    chk({nm, ".wdata"}, dmem_wdata_o, v.e_wdata);
                end
            end
            @(negedge clk);
        end
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        chk({nm, ".wb_instr"}, wb_instr_o, v.instr);
        chk({nm, ".wb_we"}, 32'(wb_we_o), 32'(v.e_we));
        chk({nm, ".misalign"}, 32'(misalign_o), 32'(v.e_mis));
        chk({nm, ".bus_err"}, 32'(bus_err_o), 32'(v.e_err));
        if (!v.e_mis && !v.e_err && k != 3) begin
            chk({nm, ".wb_data"}, wb_data_o, v.e_data);
            chk({nm, ".wb_rd"}, 32'(wb_rd_o), 32'(v.rd));
        end
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        rst_n = 1'b1; instr_i = '0; alu_result_i = '0; rs2_i = '0; sel_rd_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.ctl", 32'({stall_o, dmem_req_o, dmem_we_o, dmem_be_o}), 32'd0);
        chk("rst.addr", dmem_addr_o, 32'd0);
        chk("rst.wdata", dmem_wdata_o, 32'd0);
        chk("rst.wb_instr", wb_instr_o, 32'd0);
        chk("rst.wb_data", wb_data_o, 32'd0);
        chk("rst.wb_flags", 32'({wb_rd_o, wb_we_o, misalign_o, bus_err_o}), 32'd0);
        rst_n = 1'b1;

        //          instr                  alu           rs2           rd  g  r   rdata         addr          be     wdata         data          we mis err
        tbl.push_back(tv(mk(7'h33, 3'd0, 5), 32'h42,       32'h0,        5, 0, 0,  32'h0,        32'h0,        4'h0, 32'h0,        32'h42,       1, 0, 0));
        tbl.push_back(tv(mk(7'h03, 3'd0, 3), 32'h103,      32'h0,        3, 0, 2,  32'h80AABBCC, 32'h100,      4'h0, 32'h0,        32'hFFFFFF80, 1, 0, 0));
        tbl.push_back(tv(mk(7'h23, 3'd1, 0), 32'h202,      32'h1234ABCD, 0, 4, 0,  32'h0,        32'h200,      4'hC, 32'hABCDABCD, 32'h0,        0, 0, 0));
        tbl.push_back(tv(mk(7'h03, 3'd2, 2), 32'h001,      32'h0,        2, 0, 0,  32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        0, 1, 0));
        tbl.push_back(tv(mk(7'h03, 3'd5, 4), 32'h300,      32'h0,        4, 1, 99, 32'h0,        32'h300,      4'h0, 32'h0,        32'h0,        0, 0, 1));
        tbl.push_back(tv(mk(7'h03, 3'd2, 6), 32'h400,      32'h0,        6, 1, 0,  32'hDEADBEEF, 32'h400,      4'h0, 32'h0,        32'hDEADBEEF, 1, 0, 0));
        tbl.push_back(tv(mk(7'h03, 3'd4, 7), 32'h101,      32'h0,        7, 0, 1,  32'h123456F0, 32'h100,      4'h0, 32'h0,        32'h56,       1, 0, 0));
        tbl.push_back(tv(mk(7'h03, 3'd1, 8), 32'h102,      32'h0,        8, 2, 3,  32'h80010000, 32'h100,      4'h0, 32'h0,        32'hFFFF8001, 1, 0, 0));
        tbl.push_back(tv(mk(7'h03, 3'd5, 8), 32'h102,      32'h0,        8, 0, 4,  32'h80010000, 32'h100,      4'h0, 32'h0,        32'h00008001, 1, 0, 0));
        tbl.push_back(tv(mk(7'h03, 3'd2, 9), 32'h010,      32'h0,        9, 0, 5,  32'h0,        32'h010,      4'h0, 32'h0,        32'h0,        0, 0, 1));
        tbl.push_back(tv(mk(7'h23, 3'd0, 0), 32'h003,      32'h000000AB, 0, 0, 0,  32'h0,        32'h000,      4'h8, 32'hABABABAB, 32'h0,        0, 0, 0));
        tbl.push_back(tv(mk(7'h23, 3'd2, 0), 32'h010,      32'hCAFEF00D, 0, 1, 0,  32'h0,        32'h010,      4'hF, 32'hCAFEF00D, 32'h0,        0, 0, 0));
        tbl.push_back(tv(mk(7'h23, 3'd1, 0), 32'h201,      32'h0,        0, 0, 0,  32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        0, 1, 0));
        tbl.push_back(tv(mk(7'h03, 3'd0, 0), 32'h000,      32'h0,        0, 0, 0,  32'h7F,       32'h000,      4'h0, 32'h0,        32'h7F,       0, 0, 0));
        tbl.push_back(tv(mk(7'h33, 3'd0, 0), 32'h99,       32'h0,        0, 0, 0,  32'h0,        32'h0,        4'h0, 32'h0,        32'h99,       0, 0, 0));
        tbl.push_back(tv(mk(7'h13, 3'd0, 7), 32'h55,       32'h0,        7, 0, 0,  32'h0,        32'h0,        4'h0, 32'h0,        32'h55,       0, 0, 0));

        @(negedge clk);
        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 150; i++) begin
            int k;
            logic [2:0] f3;
            k = $urandom_range(0, 3);
            case (k)
                0: f3 = 3'd0;
                1: f3 = 3'd0;
                2: begin
                    f3 = 3'($urandom_range(0, 4));
                    if (f3 == 3'd3) f3 = 3'd5;
                end
                default: f3 = 3'($urandom_range(0, 2));
            endcase
            rv.instr   = mk((k == 0) ? 7'h33 : (k == 1) ? 7'h13 : (k == 2) ? 7'h03 : 7'h23, f3, 5'($urandom));
            rv.rd      = rv.instr[11:7];
            rv.alu     = $urandom;
            if ($urandom_range(0, 2) != 0) rv.alu = rv.alu & ~32'(size_of(rv.instr) - 1);
            rv.rs2     = $urandom;
            rv.rdata   = $urandom;
            rv.gnt_dly = $urandom_range(0, 3);
            rv.rv_dly  = $urandom_range(0, TO + 2);
            run_op(model(rv), $sformatf("rnd%0d", i));
        end

        // Reset asserted while a load waits in RESP: everything drops, late rvalid is ignored.
        instr_i = mk(7'h03, 3'd2, 9); alu_result_i = 32'h500; sel_rd_i = 5'd9;
        #1 chk("rst6.idle_stall", 32'(stall_o), 32'd1);
        @(negedge clk); dmem_gnt_i = 1'b1;
        #1 chk("rst6.req", 32'(dmem_req_o), 32'd1);
        @(negedge clk); dmem_gnt_i = 1'b0;
        #1 chk("rst6.resp", 32'({stall_o, dmem_req_o}), 32'b10);
        #2 rst_n = 1'b0;
        #1 chk("rst6.drop", 32'({stall_o, dmem_req_o}), 32'd0);
        @(negedge clk);
        instr_i = mk(7'h13, 3'd0, 0); alu_result_i = '0; sel_rd_i = '0;
        rst_n = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
        #1 chk("rst6.post_stall", 32'(stall_o), 32'd0);
        @(negedge clk); dmem_rvalid_i = 1'b0;
        chk("rst6.late_rvalid", 32'({wb_we_o, misalign_o, bus_err_o, dmem_req_o}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
